// File: rtl/arcade_video_timing.sv
// Arcade-style raster timing: pixel clock-enable divider, h/v counters,
// blanking/sync flags and blank-gated RGB, all on the single video clock.
module arcade_video_timing #(
  parameter int WIDTH    = 256,
  parameter int HEIGHT   = 224,
  parameter int H_TOTAL  = 384,
  parameter int V_TOTAL  = 262,
  parameter int HS_START = 280,
  parameter int HS_LEN   = 32,
  parameter int VS_START = 240,
  parameter int VS_LEN   = 3,
  parameter int CE_DIV   = 4,
  parameter int DW       = 8
) (
  input  logic          clk_video,
  input  logic          reset_n,
  input  logic [DW-1:0] rgb_in,
  output logic          ce_pix,
  output logic [9:0]    hcount,
  output logic [8:0]    vcount,
  output logic [DW-1:0] RGB_out,
  output logic          HBlank,
  output logic          VBlank,
  output logic          HSync,
  output logic          VSync,
  output logic          frame_start
);

  localparam logic [3:0]  CDIV_LAST = 4'(CE_DIV - 1);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [8:0]  V_LAST    = 9'(V_TOTAL - 1);
  // Extended widths so HS_START+HS_LEN == 1024 / VS_START+VS_LEN == 512 still compare correctly
  localparam logic [10:0] H_VIS     = 11'(WIDTH);
  localparam logic [10:0] HS_LO     = 11'(HS_START);
  localparam logic [10:0] HS_HI     = 11'(HS_START + HS_LEN);
  localparam logic [9:0]  V_VIS     = 10'(HEIGHT);
  localparam logic [9:0]  VS_LO     = 10'(VS_START);
  localparam logic [9:0]  VS_HI     = 10'(VS_START + VS_LEN);

  logic [3:0]  cdiv;
  logic        ce;
  logic        h_last, v_last;
  logic [10:0] h_ext;
  logic [9:0]  v_ext;
  logic        h_vis, v_vis, hs_on, vs_on;

  always_comb begin
    ce     = (cdiv == CDIV_LAST);
    h_last = (hcount == H_LAST);
    v_last = (vcount == V_LAST);
    h_ext  = {1'b0, hcount};
    v_ext  = {1'b0, vcount};
    h_vis  = (h_ext < H_VIS);
    v_vis  = (v_ext < V_VIS);
    hs_on  = (h_ext >= HS_LO) && (h_ext < HS_HI);
    vs_on  = (v_ext >= VS_LO) && (v_ext < VS_HI);
  end

  always_ff @(posedge clk_video) begin
    if (!reset_n) begin
      cdiv        <= '0;
      ce_pix      <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      RGB_out     <= '0;
      HBlank      <= 1'b1;
      VBlank      <= 1'b1;
      HSync       <= 1'b0;
      VSync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cdiv        <= ce ? '0 : cdiv + 4'd1;
      ce_pix      <= ce;
      frame_start <= ce && h_last && v_last;
      if (ce) begin
        hcount <= h_last ? '0 : hcount + 10'd1;
        if (h_last)
          vcount <= v_last ? '0 : vcount + 9'd1;
        // Flags and pixel describe the pre-increment position, one pixel behind the counters
        HBlank  <= ~h_vis;
        VBlank  <= ~v_vis;
        HSync   <= hs_on;
        VSync   <= vs_on;
        RGB_out <= (h_vis && v_vis) ? rgb_in : '0;
      end
    end
  end

endmodule

// File: tb/tb_arcade_video_timing.sv
// Directed bench: default-timing instance (A) walked pixel by pixel, and a
// tiny CE_DIV=1 raster (B) walked across several frames, both with mid-run resets.
module tb_arcade_video_timing;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_a, rstn_b;
  logic [7:0] rgb_a, rgb_b;

  logic       ce_a, hb_a, vb_a, hs_a, vs_a, fs_a;
  logic [9:0] hc_a;
  logic [8:0] vc_a;
  logic [7:0] rgbo_a;

  logic       ce_b, hb_b, vb_b, hs_b, vs_b, fs_b;
  logic [9:0] hc_b;
  logic [8:0] vc_b;
  logic [7:0] rgbo_b;

  arcade_video_timing dut_a (
    .clk_video(clk), .reset_n(rstn_a), .rgb_in(rgb_a), .ce_pix(ce_a),
    .hcount(hc_a), .vcount(vc_a), .RGB_out(rgbo_a), .HBlank(hb_a),
    .VBlank(vb_a), .HSync(hs_a), .VSync(vs_a), .frame_start(fs_a)
  );

  arcade_video_timing #(
    .WIDTH(4), .HEIGHT(2), .H_TOTAL(8), .V_TOTAL(4),
    .HS_START(5), .HS_LEN(1), .VS_START(3), .VS_LEN(1),
    .CE_DIV(1), .DW(8)
  ) dut_b (
    .clk_video(clk), .reset_n(rstn_b), .rgb_in(rgb_b), .ce_pix(ce_b),
    .hcount(hc_b), .vcount(vc_b), .RGB_out(rgbo_b), .HBlank(hb_b),
    .VBlank(vb_b), .HSync(hs_b), .VSync(vs_b), .frame_start(fs_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] pat(input int p, input int v);
    return 8'(p * 7 + v * 13) ^ 8'h5A;
  endfunction

  task automatic check_reset(input bit b);
    string s = b ? "B " : "A ";
    check({s, "rst ce_pix"},      32'(b ? ce_b   : ce_a),   0);
    check({s, "rst hcount"},      32'(b ? hc_b   : hc_a),   0);
    check({s, "rst vcount"},      32'(b ? vc_b   : vc_a),   0);
    check({s, "rst RGB_out"},     32'(b ? rgbo_b : rgbo_a), 0);
    check({s, "rst HBlank"},      32'(b ? hb_b   : hb_a),   1);
    check({s, "rst VBlank"},      32'(b ? vb_b   : vb_a),   1);
    check({s, "rst HSync"},       32'(b ? hs_b   : hs_a),   0);
    check({s, "rst VSync"},       32'(b ? vs_b   : vs_a),   0);
    check({s, "rst frame_start"}, 32'(b ? fs_b   : fs_a),   0);
  endtask

  // Expected state right after the ce edge that processed pixel (p,v)
  task automatic check_pixel(input bit b, input int p, input int v);
    string s   = b ? "B " : "A ";
    int    ht  = b ? 8 : 384;
    int    vt  = b ? 4 : 262;
    int    wd  = b ? 4 : 256;
    int    hg  = b ? 2 : 224;
    int    hss = b ? 5 : 280;
    int    hsl = b ? 1 : 32;
    int    vss = b ? 3 : 240;
    int    vsl = b ? 1 : 3;
    int    hn  = (p + 1) % ht;
    int    vn  = (p == ht - 1) ? (v + 1) % vt : v;
    logic [7:0] rexp = (p < wd && v < hg) ? pat(p, v) : 8'h00;
    check({s, "ce_pix"},      32'(b ? ce_b   : ce_a),   1);
    check({s, "hcount"},      32'(b ? hc_b   : hc_a),   32'(hn));
    check({s, "vcount"},      32'(b ? vc_b   : vc_a),   32'(vn));
    check({s, "HBlank"},      32'(b ? hb_b   : hb_a),   32'(p >= wd));
    check({s, "VBlank"},      32'(b ? vb_b   : vb_a),   32'(v >= hg));
    check({s, "HSync"},       32'(b ? hs_b   : hs_a),   32'(p >= hss && p < hss + hsl));
    check({s, "VSync"},       32'(b ? vs_b   : vs_a),   32'(v >= vss && v < vss + vsl));
    check({s, "RGB_out"},     32'(b ? rgbo_b : rgbo_a), 32'(rexp));
    check({s, "frame_start"}, 32'(b ? fs_b   : fs_a),   32'(p == ht - 1 && v == vt - 1));
  endtask

  task automatic walk(input bit b, input int v0, input int p0, input int npix);
    int p  = p0;
    int v  = v0;
    int ht = b ? 8 : 384;
    int vt = b ? 4 : 262;
    int cd = b ? 1 : 4;
    string s = b ? "B " : "A ";
    for (int i = 0; i < npix; i++) begin
      if (b) rgb_b = pat(p, v);
      else   rgb_a = pat(p, v);
      for (int k = 1; k < cd; k++) begin
        tick();
        check({s, "ce_pix idle"}, 32'(b ? ce_b : ce_a), 0);
        check({s, "hcount hold"}, 32'(b ? hc_b : hc_a), 32'(p));
      end
      tick();
      check_pixel(b, p, v);
      if (p == ht - 1) begin
        p = 0;
        v = (v + 1) % vt;
      end else begin
        p++;
      end
    end
  endtask

  initial begin
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    rgb_a  = 8'h00;
    rgb_b  = 8'h00;
    repeat (3) tick();
    check_reset(1'b0);
    check_reset(1'b1);

    // A: two full lines plus 100 pixels of line 2
    rstn_a = 1'b1;
    walk(1'b0, 0, 0, 2 * 384 + 100);
    check("A hcount at 100", 32'(hc_a), 100);
    check("A vcount at 2", 32'(vc_a), 2);

    // A: one-clk reset mid-pixel, mid-line
    tick();
    rstn_a = 1'b0;
    tick();
    check_reset(1'b0);
    rstn_a = 1'b1;
    walk(1'b0, 0, 0, 10);

    // A: constant white on the visible area of line 0 after a fresh reset
    rstn_a = 1'b0;
    tick();
    rstn_a = 1'b1;
    rgb_a  = 8'hFF;
    repeat (4) tick();
    check("A white px0 RGB_out", 32'(rgbo_a), 32'hFF);
    repeat (4 * 255) tick();
    check("A white px255 RGB_out", 32'(rgbo_a), 32'hFF);
    check("A white px255 HBlank", 32'(hb_a), 0);
    repeat (4) tick();
    check("A white px256 RGB_out", 32'(rgbo_a), 32'h00);
    check("A white px256 HBlank", 32'(hb_a), 1);

    // B: three whole frames, then a mid-frame reset and restart
    rstn_b = 1'b1;
    walk(1'b1, 0, 0, 3 * 32);
    walk(1'b1, 0, 0, 27);
    rstn_b = 1'b0;
    tick();
    check_reset(1'b1);
    rstn_b = 1'b1;
    walk(1'b1, 0, 0, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
